// File: rtl/video_rd_unpack.sv
// Read-side 256-to-32-bit unpacking buffer for the frame-buffer path.
// Two-entry ping-pong store, FWFT pixel output, line position tracking and sticky errors.
module video_rd_unpack #(
    parameter int unsigned LINE_PIX = 1920,
    parameter int unsigned PIX_W    = 32,
    parameter int unsigned WORD_W   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_vld,
    input  logic              rd_en,
    output logic              rd_vld,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_last,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int unsigned LANES  = WORD_W / PIX_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PIX_CW = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [PIX_CW-1:0] PIX_LAST  = PIX_CW'(LINE_PIX - 1);

    logic [LANES-1:0][PIX_W-1:0] r_mem [2];
    logic                        r_wp;
    logic                        r_rp;
    logic [1:0]                  r_count;
    logic [LANE_W-1:0]           r_lane;
    logic [PIX_CW-1:0]           r_pix_cnt;
    logic                        r_ovf;
    logic                        r_udf;

    logic                        w_clear;
    logic                        w_wr_acc;
    logic                        w_rd_acc;
    logic                        w_word_done;
    logic [LANES-1:0][PIX_W-1:0] w_rd_word;

    // Flow-control flags decode straight from the occupancy register.
    assign wr_vld = (r_count != 2'd2);
    assign rd_vld = (r_count != 2'd0);

    assign w_clear     = rst | flush;
    assign w_wr_acc    = wr_en & wr_vld & ~w_clear;
    assign w_rd_acc    = rd_en & rd_vld & ~w_clear;
    assign w_word_done = w_rd_acc & (r_lane == LANE_LAST);

    assign w_rd_word = r_mem[r_rp];
    assign rd_data   = w_rd_word[r_lane];
    assign rd_last   = rd_vld & (r_pix_cnt == PIX_LAST);
    assign ovf_err   = r_ovf;
    assign udf_err   = r_udf;

    // Word storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_count   <= 2'd0;
            r_lane    <= '0;
            r_pix_cnt <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (wr_en & ~wr_vld) begin
                r_ovf <= 1'b1;
            end
            if (rd_en & ~rd_vld) begin
                r_udf <= 1'b1;
            end

            if (w_wr_acc) begin
                r_wp <= ~r_wp;
            end

            if (w_rd_acc) begin
                r_lane    <= w_word_done ? '0 : r_lane + LANE_W'(1);
                r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + PIX_CW'(1);
            end
            if (w_word_done) begin
                r_rp <= ~r_rp;
            end

            // Write and last-lane read in the same cycle leave occupancy unchanged.
            case ({w_wr_acc, w_word_done})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_video_rd_unpack.sv
// Scoreboard bench for video_rd_unpack: expected pixels are queued on each
// predicted write acceptance and compared as the DUT presents them.
module tb_video_rd_unpack;

    localparam int unsigned LP = 12;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         wr_en;
    logic [255:0] wr_data;
    logic         wr_vld;
    logic         rd_en;
    logic         rd_vld;
    logic [31:0]  rd_data;
    logic         rd_last;
    logic         ovf_err;
    logic         udf_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int          m_pix = 0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    video_rd_unpack #(.LINE_PIX(LP), .PIX_W(32), .WORD_W(256)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_vld  (wr_vld),
        .rd_en   (rd_en),
        .rd_vld  (rd_vld),
        .rd_data (rd_data),
        .rd_last (rd_last),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] mk_word(input logic [23:0] tag);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = {tag, 8'(k)};
        return w;
    endfunction

    // Compare current outputs against the model, apply inputs for one edge, advance the model.
    task automatic step(input logic wr, input logic [255:0] d, input logic rd,
                        input logic fl, input logic rs);
        int  cnt;
        bit  wr_ok;
        bit  rd_ok;
        rst     = rs;
        flush   = fl;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        cnt = (exp_q.size() + 7) / 8;
        check("wr_vld", 32'(wr_vld), 32'(cnt < 2));
        check("rd_vld", 32'(rd_vld), 32'(exp_q.size() > 0));
        check("ovf_err", 32'(ovf_err), 32'(m_ovf));
        check("udf_err", 32'(udf_err), 32'(m_udf));
        if (exp_q.size() > 0) begin
            check("rd_data", rd_data, exp_q[0]);
            check("rd_last", 32'(rd_last), 32'(m_pix == int'(LP) - 1));
        end else begin
            check("rd_last_idle", 32'(rd_last), 32'd0);
        end

        if (rs || fl) begin
            exp_q.delete();
            m_pix = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            wr_ok = wr && (cnt < 2);
            rd_ok = rd && (exp_q.size() > 0);
            if (wr && !wr_ok) m_ovf = 1'b1;
            if (rd && !rd_ok) m_udf = 1'b1;
            if (rd_ok) begin
                void'(exp_q.pop_front());
                m_pix = (m_pix == int'(LP) - 1) ? 0 : m_pix + 1;
            end
            if (wr_ok) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(d[k*32 +: 32]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr_word(input logic [23:0] tag);
        step(1'b1, mk_word(tag), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // Single word, continuous read of lanes 0..7.
        step(1'b1, mk_word(24'h0), 1'b0, 1'b0, 1'b0);
        rd_n(8);
        idle();

        // Full buffer: third write is dropped and flags overflow.
        wr_word(24'h000A01);
        wr_word(24'h000A02);
        wr_word(24'h000A03);
        rd_n(16);
        idle();

        // Streaming with lines straddling words, pixel counter restarted by flush.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        wr_word(24'h000B00);
        for (int i = 0; i < 24; i++)
            step(i == 0 || i == 8, mk_word(24'(24'h000B01 + i / 8)), 1'b1, 1'b0, 1'b0);
        idle();

        // Write coinciding with the last-lane read at count 1.
        wr_word(24'h000C00);
        rd_n(7);
        step(1'b1, mk_word(24'h000C01), 1'b1, 1'b0, 1'b0);
        rd_n(8);
        idle();

        // Underflow, then flush mid-word with simultaneous write and read.
        rd_n(1);
        idle();
        wr_word(24'h000D00);
        wr_word(24'h000D01);
        rd_n(3);
        step(1'b1, mk_word(24'h000D02), 1'b1, 1'b1, 1'b0);
        idle();
        wr_word(24'h000D03);
        rd_n(8);
        idle();

        // Reset mid-stream at lane 5 with two words held.
        wr_word(24'h000E00);
        wr_word(24'h000E01);
        rd_n(5);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        wr_word(24'h000E02);
        rd_n(8);
        idle();

        // Random traffic including occasional flushes.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) == 0, mk_word(24'($urandom)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0, 1'b0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_rd_unpack.md
# video_rd_unpack

Single-clock read-side width converter for the video frame-buffer path: accepts 256-bit words fetched from DDR and delivers them as a first-word-fall-through stream of 32-bit pixels to the display timing logic. It is the unpacking counterpart of the 32-to-256-bit packing FIFO on the write side. It holds up to two 256-bit words. It also tracks pixel position within a line so it can flag end-of-line, and it records sticky overflow/underflow errors.

## Interface
Parameters:
- LINE_PIX, 1920: active pixels per line; legal 1..65535; need not be a multiple of 8.
- PIX_W, 32: output pixel width; fixed at 32 in this revision.
- WORD_W, 256: input word width; must equal 8*PIX_W.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous buffer clear (start of frame).
- wr_en  in  1  write strobe for wr_data.
- wr_data  in  256  packed word; pixel 0 in bits [31:0], pixel 7 in bits [255:224].
- wr_vld  out  1  space available; a write is accepted only when wr_en & wr_vld.
- rd_en  in  1  pixel consume strobe; a read is accepted only when rd_en & rd_vld.
- rd_vld  out  1  rd_data holds a valid pixel.
- rd_data  out  32  current pixel (FWFT, valid whenever rd_vld=1).
- rd_last  out  1  current pixel is the last pixel of a line.
- ovf_err  out  1  sticky: a write was attempted while wr_vld=0.
- udf_err  out  1  sticky: a read was attempted while rd_vld=0.

## Operation
- Storage: two 256-bit entries (ping-pong), write pointer wp and read pointer rp (1 bit each), count (0..2), lane index (0..7), pixel counter pix_cnt (0..LINE_PIX-1).
- wr_vld = (count != 2). rd_vld = (count != 0). Both are decoded from registers only and have no combinational path from wr_en or rd_en.
- rd_data = mem[rp][lane*32 +: 32]. Lanes are emitted in order 0 to 7.
- Accepted write: mem[wp] <= wr_data, wp toggles, count+1.
- Accepted read:
  - lane+1.
  - When lane==7: lane <= 0, rp toggles, count-1.
  - pix_cnt+1, wrapping to 0 after LINE_PIX-1.
- Simultaneous accepted write and a read of lane 7: count is unchanged and both pointers advance.
- A write is never accepted at count==2, even if the same cycle frees an entry.
- rd_last = rd_vld & (pix_cnt == LINE_PIX-1).
- Line boundaries are independent of word boundaries. A word may straddle two lines.
- Rejected write (wr_en & !wr_vld): data is dropped, no state changes, ovf_err <= 1.
- Rejected read (rd_en & !rd_vld): no state changes, udf_err <= 1.
- flush: count, wp, rp, lane and pix_cnt are cleared to 0, and ovf_err and udf_err are cleared. flush overrides any write or read in the same cycle; both are discarded and no error is flagged.
- rst has the same effect as flush, and takes priority over it.

## Timing
- Reset values (cycle after rst is sampled high): wr_vld=1, rd_vld=0, rd_last=0, ovf_err=0, udf_err=0. rd_data is don't-care while rd_vld=0.
- Write-to-read latency: a write accepted at edge N into an empty buffer gives rd_vld=1 with pixel 0 on rd_data from edge N onward, i.e. 1 cycle.
- Read throughput: 1 pixel per cycle with rd_en held high, provided the writer supplies one word per 8 cycles.
- Backpressure: wr_vld falls the cycle after the second entry is written. It rises the cycle after lane 7 of the oldest entry is consumed.
- Mid-operation reset or flush: state clears on the sampling edge. No partial word survives.

## Test plan
- **Single word, continuous read.** Write 0x{8{...}} with lanes 0x00000000..0x00000007, then hold rd_en=1. Expected: rd_data sequence 0..7 on consecutive cycles, rd_vld drops after the 8th pixel, udf_err stays 0.
- **Full buffer.** Write 3 words back-to-back with no reads. Expected: words 1 and 2 are accepted and wr_vld=0 after the 2nd. The 3rd is dropped with ovf_err=1. Reading 16 pixels returns only words 1 and 2.
- **Streaming with a line straddling words.** LINE_PIX=12, stream 3 words with rd_en=1. Expected: rd_last=1 exactly on pixels 11 and 23, no bubbles after the first word, and count never exceeds 2.
- **Simultaneous write and last-lane read.** At count==1, assert wr_en in the same cycle as lane 7 is read. Expected: count stays 1, and the next cycle shows lane 0 of the new word.
- **Underflow and flush.** rd_en pulsed while empty sets udf_err=1. Then, mid-word (lane 3) with count==2, assert flush together with wr_en and rd_en. Expected next cycle: rd_vld=0, wr_vld=1, errors cleared, pix_cnt=0, and the write is discarded.
- **Reset mid-stream.** Assert rst at lane 5 with count==2. Expected: all outputs at reset values on the next cycle, and a fresh word then reads out from lane 0.
